// File: rtl/dc7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display scanner.
package dc7_pkg;

    localparam int unsigned NDIG_MIN = 2;
    localparam int unsigned NDIG_MAX = 8;
    localparam int unsigned DIV_MIN  = 2;

    // Counter width able to hold 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic an_active(input bit an_low);
        return an_low ? 1'b0 : 1'b1;
    endfunction

    function automatic logic an_idle(input bit an_low);
        return an_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/dc7_tick.sv
// Digit-slot prescaler: counts 0..DIV-1, flags the last cycle (tick) and first cycle of a slot.
module dc7_tick
    import dc7_pkg::*;
#(
    parameter int unsigned DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic slot_start
);

    localparam int unsigned   PW         = cnt_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        slot_start = (presc_q == '0);
        presc_d    = tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/dc7_scan.sv
// Multiplexed display scanner: double-buffered digit word, one nibble per slot onto d_out,
// matching digit select on an, optional leading-zero blanking.
module dc7_scan
    import dc7_pkg::*;
#(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned DIV    = 1000,
    parameter bit          AN_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [4*NDIG-1:0] load_data,
    input  logic              blank_lz,
    output logic [3:0]        d_out,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int unsigned      IDX_W    = cnt_width(NDIG);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic             AN_ON    = an_active(AN_LOW);
    localparam logic             AN_OFF   = an_idle(AN_LOW);

    if (NDIG < NDIG_MIN || NDIG > NDIG_MAX || DIV < DIV_MIN) begin : g_param_check
        $error("dc7_scan: NDIG or DIV out of range");
    end

    logic              tick, slot_start, accept, zero_run;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d, pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [3:0]        d_out_q, d_out_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [NDIG-1:0]   blank;

    dc7_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .slot_start(slot_start)
    );

    // Digit i is blanked when every nibble from the top down to i is zero; digit 0 never is.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_run = zero_run && (shadow_q[4*i +: 4] == 4'h0);
            blank[i] = blank_lz && zero_run;
        end
    end

    always_comb begin
        frame_done  = tick && (idx_q == IDX_LAST) && !rst;
        load_ready  = !pend_full_q && !rst;
        accept      = load_valid && load_ready;

        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        d_out_d     = d_out_q;
        an_d        = an_q;

        // Accept can only coincide with a boundary when pending was already empty.
        if (frame_done && pend_full_q) begin
            shadow_d    = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end

        if (tick) begin
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            d_out_d = shadow_d[4*idx_d +: 4];
            an_d    = {NDIG{AN_OFF}};
        end else if (slot_start) begin
            // Selects stay dark for the first cycle of each slot to hide ghosting.
            for (int i = 0; i < NDIG; i++) begin
                an_d[i] = (idx_q == IDX_W'(i) && !blank[i]) ? AN_ON : AN_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            shadow_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            d_out_q     <= 4'h0;
            an_q        <= {NDIG{AN_OFF}};
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            d_out_q     <= d_out_d;
            an_q        <= an_d;
        end
    end

    assign d_out = d_out_q;
    assign an    = an_q;

endmodule
